// File: rtl/dco_delay_calibrator_if.sv
// Control, status and sample-capture bundle between the DCO delay calibrator and its environment.
// The calibrator takes the slave view.
interface dco_delay_calibrator_if #(
    parameter int unsigned DATA_W = 14
) ();
    logic              start;
    logic [DATA_W-1:0] smp_data;
    logic              smp_valid;
    logic [2:0]        delay;
    logic              busy;
    logic              done;
    logic              locked;
    logic              fail;
    logic [7:0]        pass_mask;

    modport master (
        output start, smp_data, smp_valid,
        input  delay, busy, done, locked, fail, pass_mask
    );

    modport slave (
        input  start, smp_data, smp_valid,
        output delay, busy, done, locked, fail, pass_mask
    );
endinterface

// File: rtl/dco_delay_calibrator.sv
// Sweeps the 3-bit DCO delay tap and checks the ADC checkerboard pattern at each tap.
// It then parks the tap at the centre of the widest passing window.
module dco_delay_calibrator #(
    parameter int unsigned       DATA_W        = 14,
    parameter int unsigned       SETTLE_CYC    = 16,
    parameter int unsigned       CHECK_LEN     = 64,
    parameter logic [2:0]        DEFAULT_DELAY = 3'd0,
    parameter logic [DATA_W-1:0] PAT_A         = 14'h2AAA,
    parameter logic [DATA_W-1:0] PAT_B         = 14'h1555
) (
    input logic                   in_clk_p,
    input logic                   reset_n,
    dco_delay_calibrator_if.slave cal
);

    localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned CW = $clog2(CHECK_LEN);
    localparam logic [SW-1:0] SettleLast = SW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] CheckLast  = CW'(CHECK_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSet,
        StSettle,
        StCheck,
        StNext,
        StEval,
        StDone
    } state_e;

    state_e      state_q;
    logic [2:0]  tap_q;
    logic [2:0]  delay_q;
    logic        busy_q;
    logic        done_q;
    logic        locked_q;
    logic        fail_q;
    logic [7:0]  mask_q;
    logic [SW-1:0] settle_cnt_q;
    logic [CW-1:0] smp_cnt_q;
    logic        err_q;
    logic        exp_b_q;

    // Longest run of passing taps; strict '>' keeps the lowest start on ties.
    logic [3:0] run_len, best_len;
    logic [2:0] run_start, best_start, sel;

    always_comb begin
        run_len    = 4'd0;
        run_start  = 3'd0;
        best_len   = 4'd0;
        best_start = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (mask_q[i]) begin
                if (run_len == 4'd0) run_start = 3'(i);
                run_len = run_len + 4'd1;
                if (run_len > best_len) begin
                    best_len   = run_len;
                    best_start = run_start;
                end
            end else begin
                run_len = 4'd0;
            end
        end
        sel = best_start + 3'((best_len - 4'd1) >> 1);
    end

    always_ff @(posedge in_clk_p or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            tap_q        <= 3'd0;
            delay_q      <= DEFAULT_DELAY;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            locked_q     <= 1'b0;
            fail_q       <= 1'b0;
            mask_q       <= 8'h00;
            settle_cnt_q <= '0;
            smp_cnt_q    <= '0;
            err_q        <= 1'b0;
            exp_b_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A start coinciding with the done pulse is dropped.
                    if (cal.start && !done_q) begin
                        state_q  <= StSet;
                        tap_q    <= 3'd0;
                        busy_q   <= 1'b1;
                        mask_q   <= 8'h00;
                        locked_q <= 1'b0;
                        fail_q   <= 1'b0;
                    end
                end
                StSet: begin
                    delay_q      <= tap_q;
                    settle_cnt_q <= '0;
                    smp_cnt_q    <= '0;
                    err_q        <= 1'b0;
                    exp_b_q      <= 1'b0;
                    state_q      <= StSettle;
                end
                StSettle: begin
                    if (settle_cnt_q == SettleLast) state_q <= StCheck;
                    else settle_cnt_q <= settle_cnt_q + SW'(1);
                end
                StCheck: begin
                    if (cal.smp_valid) begin
                        if (smp_cnt_q == '0) begin
                            // First sample picks the phase of the alternation.
                            if (cal.smp_data == PAT_A) begin
                                exp_b_q <= 1'b1;
                            end else if (cal.smp_data == PAT_B) begin
                                exp_b_q <= 1'b0;
                            end else begin
                                err_q   <= 1'b1;
                                exp_b_q <= 1'b0;
                            end
                        end else begin
                            if (cal.smp_data != (exp_b_q ? PAT_B : PAT_A)) err_q <= 1'b1;
                            exp_b_q <= ~exp_b_q;
                        end
                        if (smp_cnt_q == CheckLast) state_q <= StNext;
                        else smp_cnt_q <= smp_cnt_q + CW'(1);
                    end
                end
                StNext: begin
                    mask_q[tap_q] <= ~err_q;
                    if (tap_q == 3'd7) begin
                        state_q <= StEval;
                    end else begin
                        tap_q   <= tap_q + 3'd1;
                        state_q <= StSet;
                    end
                end
                StEval: begin
                    if (best_len != 4'd0) begin
                        delay_q  <= sel;
                        locked_q <= 1'b1;
                    end else begin
                        delay_q <= DEFAULT_DELAY;
                        fail_q  <= 1'b1;
                    end
                    state_q <= StDone;
                end
                StDone: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cal.delay     = delay_q;
    assign cal.busy      = busy_q;
    assign cal.done      = done_q;
    assign cal.locked    = locked_q;
    assign cal.fail      = fail_q;
    assign cal.pass_mask = mask_q;

endmodule

// File: tb/tb_dco_delay_calibrator.sv
// Directed bench for dco_delay_calibrator: per-tap sample corruption, valid gaps,
// stray starts and mid-sweep reset, all against hand-computed results.
module tb_dco_delay_calibrator;

    localparam int unsigned DATA_W = 14;
    localparam logic [13:0] PA     = 14'h2AAA;
    localparam logic [13:0] PB     = 14'h1555;
    localparam int          MinLat = 8 * (1 + 16 + 64 + 1) + 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dco_delay_calibrator_if #(.DATA_W(DATA_W)) sif ();

    dco_delay_calibrator #(
        .DATA_W        (DATA_W),
        .SETTLE_CYC    (16),
        .CHECK_LEN     (64),
        .DEFAULT_DELAY (3'd0),
        .PAT_A         (PA),
        .PAT_B         (PB)
    ) dut (
        .in_clk_p (clk),
        .reset_n  (rst_n),
        .cal      (sif)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] bad_taps    = 8'h00;
    bit         spike       = 1'b0;
    int         valid_div   = 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sample source: continuous checkerboard, corrupted per tap or by a periodic spike.
    initial begin
        int         div  = 0;
        int         vcnt = 0;
        bit         ph   = 1'b0;
        logic [13:0] word;
        bit         vld;
        sif.smp_data  = PA;
        sif.smp_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            div++;
            vld  = (div % valid_div) == 0;
            word = sif.smp_data;
            if (vld) begin
                word = ph ? PB : PA;
                ph   = ~ph;
                vcnt++;
                if (bad_taps[sif.delay]) word = 14'h0000;
                if (spike && (vcnt % 50) == 40) word = 14'h0000;
            end
            sif.smp_data  = word;
            sif.smp_valid = vld;
        end
    end

    task automatic run_cal(input int stray, output int n);
        @(negedge clk);
        sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        n = 1;
        check("busy_up", sif.busy, 1);
        check("clr_locked", sif.locked, 0);
        check("clr_fail", sif.fail, 0);
        check("clr_mask", sif.pass_mask, 0);
        while (!sif.done && n < 20000) begin
            @(negedge clk);
            n++;
            sif.start = (stray != 0) && ((n % stray) == 0);
        end
        sif.start = 1'b0;
        check("done_seen", sif.done, 1);
        check("busy_at_done", sif.busy, 0);
    endtask

    task automatic check_result(input string tag, input logic [7:0] mask, input logic [2:0] dly,
                                input logic lck, input logic fl);
        check({tag, "_mask"}, sif.pass_mask, mask);
        check({tag, "_delay"}, sif.delay, dly);
        check({tag, "_locked"}, sif.locked, lck);
        check({tag, "_fail"}, sif.fail, fl);
    endtask

    initial begin
        int n;
        sif.start = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_delay", sif.delay, 0);
        check("rst_busy", sif.busy, 0);
        check("rst_done", sif.done, 0);
        check("rst_locked", sif.locked, 0);
        check("rst_fail", sif.fail, 0);
        check("rst_mask", sif.pass_mask, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: all clean, with start coinciding with done
        bad_taps = 8'h00;
        run_cal(0, n);
        check("c1_latency", n, MinLat);
        check_result("c1", 8'hFF, 3'd3, 1'b1, 1'b0);
        sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        check("c1_done_pulse", sif.done, 0);
        check("c1_start_on_done", sif.busy, 0);
        repeat (3) @(negedge clk);
        check("c1_idle_hold", sif.busy, 0);
        check("c1_delay_hold", sif.delay, 3);

        // 2: taps 2..5 clean
        bad_taps = 8'hC3;
        run_cal(0, n);
        check_result("c2", 8'h3C, 3'd3, 1'b1, 1'b0);

        // 4: one bad sample in every check window
        bad_taps = 8'h00;
        spike    = 1'b1;
        run_cal(0, n);
        check_result("c4", 8'h00, 3'd0, 1'b0, 1'b1);
        spike = 1'b0;

        // 3a: runs 0-1 and 4-6
        bad_taps = 8'h8C;
        run_cal(0, n);
        check_result("c3a", 8'h73, 3'd5, 1'b1, 1'b0);

        // 3b: tie between 0-1 and 4-5
        bad_taps = 8'hCC;
        run_cal(0, n);
        check_result("c3b", 8'h33, 3'd0, 1'b1, 1'b0);

        // 5: valid 1-in-3 and stray starts mid-sweep
        bad_taps  = 8'h00;
        valid_div = 3;
        run_cal(300, n);
        check("c5_later", n > MinLat, 1);
        check_result("c5", 8'hFF, 3'd3, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("c5_no_restart", sif.busy, 0);
        valid_div = 1;

        // 6: reset during CHECK of tap 4, then a full sweep
        @(negedge clk);
        sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        n = 0;
        while (sif.delay != 3'd4 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("c6_reach_tap4", sif.delay, 4);
        repeat (30) @(negedge clk);
        check("c6_mask_pre", sif.pass_mask, 8'h0F);
        rst_n = 1'b0;
        #1;
        check("c6_rst_delay", sif.delay, 0);
        check("c6_rst_busy", sif.busy, 0);
        check("c6_rst_mask", sif.pass_mask, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_cal(0, n);
        check("c6_latency", n, MinLat);
        check_result("c6", 8'hFF, 3'd3, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
